echo_delay_buffer: RTL and testbench

//  Per-channel circular buffer of received echo samples. Sits directly downstream
//  of the delay calculator: takes its 8-bit delay (in samples) and returns the echo

---
 rtl/echo_delay_buffer.sv | 138 +++++++++++++
 tb/tb_echo_delay_buffer.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/echo_delay_buffer.sv
// echo_delay_buffer
//   Per-channel circular buffer of received echo samples. Incoming samples are
//   written continuously. A delay request returns the sample that was received
//   delay_in samples before the newest stored one. If the buffer does not yet
//   hold that much history, the request returns zero and flags underrun.
//
// Ports
//   clk, reset        rising-edge clock; asynchronous active-high reset
//   flush             synchronous clear of write pointer, fill level and FSM
//   sample_valid      write strobe for sample_in
//   sample_in         echo sample, stored untouched
//   delay_valid/ready delay request handshake (ready only while idle)
//   delay_in          delay in samples, 0 = newest stored sample
//   out_valid/ready   delayed-sample handshake; outputs held until accepted
//   out_sample        delayed sample, 0 on underrun
//   out_underrun      requested delay exceeded stored history
//   fill_level        number of stored samples, saturates at DEPTH
module echo_delay_buffer #(
    parameter int DATA_W  = 16,
    parameter int DELAY_W = 8,
    parameter int ADDR_W  = 9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               sample_valid,
    input  logic [DATA_W-1:0]  sample_in,
    input  logic               delay_valid,
    input  logic [DELAY_W-1:0] delay_in,
    output logic               delay_ready,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_sample,
    output logic               out_underrun,
    output logic [ADDR_W:0]    fill_level
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        OUT
    } state_t;

    state_t state, state_next;

    logic [DATA_W-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0]  wr_ptr;
    logic [ADDR_W-1:0]  rd_addr;
    logic               underrun_q;
    logic               accept;
    logic [ADDR_W-1:0]  delay_addr;
    logic [ADDR_W:0]    delay_cmp;

    assign delay_addr  = {{(ADDR_W - DELAY_W){1'b0}}, delay_in};
    assign delay_cmp   = {{(ADDR_W + 1 - DELAY_W){1'b0}}, delay_in};
    assign delay_ready = (state == IDLE) && !reset;
    // A flush in the accept cycle drops the request along with everything else.
    assign accept      = (state == IDLE) && delay_valid && !flush;

    // Sample storage; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (sample_valid && !flush) begin
            mem[wr_ptr] <= sample_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            fill_level <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            fill_level <= '0;
        end else if (sample_valid) begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
            if (fill_level != FULL) begin
                fill_level <= fill_level + (ADDR_W + 1)'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (delay_valid) state_next = READ;
                READ:    state_next = OUT;
                OUT:     if (out_ready) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Address and underrun use this cycle's pre-write pointer and fill level,
    // so a sample written in the accept cycle is not visible to the request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_addr    <= '0;
            underrun_q <= 1'b0;
        end else if (accept) begin
            rd_addr    <= wr_ptr - ADDR_W'(1) - delay_addr;
            underrun_q <= (delay_cmp >= fill_level);
        end
    end

    // The memory read happens in READ and lands directly in the output
    // register, so out_valid rises two cycles after acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid    <= 1'b0;
            out_sample   <= '0;
            out_underrun <= 1'b0;
        end else if (flush) begin
            out_valid    <= 1'b0;
            out_underrun <= 1'b0;
        end else if (state == READ) begin
            out_valid    <= 1'b1;
            out_underrun <= underrun_q;
            out_sample   <= underrun_q ? '0 : mem[rd_addr];
        end else if ((state == OUT) && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_echo_delay_buffer.sv
module tb_echo_delay_buffer;

    localparam int DATA_W  = 16;
    localparam int DELAY_W = 8;
    localparam int ADDR_W  = 9;
    localparam int DEPTH   = 512;

    logic               clk = 1'b0;
    logic               reset;
    logic               flush;
    logic               sample_valid;
    logic [DATA_W-1:0]  sample_in;
    logic               delay_valid;
    logic [DELAY_W-1:0] delay_in;
    logic               delay_ready;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  out_sample;
    logic               out_underrun;
    logic [ADDR_W:0]    fill_level;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    // Reference history: every sample written since the last flush/reset.
    logic [DATA_W-1:0] hist [$];

    always #5 clk = ~clk;

    echo_delay_buffer #(
        .DATA_W (DATA_W),
        .DELAY_W(DELAY_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .sample_valid(sample_valid),
        .sample_in   (sample_in),
        .delay_valid (delay_valid),
        .delay_in    (delay_in),
        .delay_ready (delay_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sample  (out_sample),
        .out_underrun(out_underrun),
        .fill_level  (fill_level)
    );

    function automatic int exp_fill();
        return (hist.size() > DEPTH) ? DEPTH : hist.size();
    endfunction

    function automatic logic exp_under(input int d);
        return d >= exp_fill();
    endfunction

    function automatic logic [DATA_W-1:0] exp_sample(input int d);
        if (exp_under(d)) return '0;
        return hist[hist.size() - 1 - d];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic write_one(input logic [DATA_W-1:0] v);
        sample_valid = 1'b1;
        sample_in    = v;
        tick();
        sample_valid = 1'b0;
        hist.push_back(v);
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        hist.delete();
    endtask

    // Issues one request from IDLE; lat = edges from the accept edge to out_valid, plus one.
    task automatic do_request(input int d, input bit consume,
                              output logic [DATA_W-1:0] s, output logic u, output int lat);
        delay_valid = 1'b1;
        delay_in    = DELAY_W'(d);
        tick();
        delay_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        s = out_sample;
        u = out_underrun;
        if (consume) begin
            out_ready = 1'b1;
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        total++;
        if (delay_ready !== 1'b0) $display("FAIL reset_ready: got %b expected 0", delay_ready);
        else passed++;
        total++;
        if (out_valid !== 1'b0 || out_underrun !== 1'b0 || out_sample !== '0)
            $display("FAIL reset_out: got valid=%b under=%b sample=%h expected 0 0 0000",
                     out_valid, out_underrun, out_sample);
        else passed++;
        total++;
        if (fill_level !== '0) $display("FAIL reset_fill: got %0d expected 0", fill_level);
        else passed++;
        reset = 1'b0;
        hist.delete();
        tick();
        total++;
        if (delay_ready !== 1'b1) $display("FAIL reset_release_ready: got %b expected 1", delay_ready);
        else passed++;
    endtask

    task automatic test_basic();
        logic [DATA_W-1:0] s;
        logic u;
        int lat;
        int ds [3] = '{0, 15, 16};
        do_flush();
        for (int i = 0; i < 16; i++) write_one(DATA_W'(16'h0100 + i));
        total++;
        if (fill_level !== 10'(exp_fill())) $display("FAIL basic_fill: got %0d expected %0d", fill_level, exp_fill());
        else passed++;
        for (int k = 0; k < 3; k++) begin
            do_request(ds[k], 1'b1, s, u, lat);
            total++;
            if (s !== exp_sample(ds[k]) || u !== exp_under(ds[k]) || lat != 2)
                $display("FAIL basic_d%0d: got sample=%h under=%b lat=%0d expected sample=%h under=%b lat=2",
                         ds[k], s, u, lat, exp_sample(ds[k]), exp_under(ds[k]));
            else passed++;
        end
    endtask

    task automatic test_wrap();
        logic [DATA_W-1:0] s;
        logic u;
        int lat;
        int ds [2] = '{255, 0};
        do_flush();
        for (int i = 0; i < 600; i++) write_one(DATA_W'(i));
        total++;
        if (fill_level !== 10'(exp_fill())) $display("FAIL wrap_fill: got %0d expected %0d", fill_level, exp_fill());
        else passed++;
        for (int k = 0; k < 2; k++) begin
            do_request(ds[k], 1'b1, s, u, lat);
            total++;
            if (s !== exp_sample(ds[k]) || u !== 1'b0)
                $display("FAIL wrap_d%0d: got sample=%0d under=%b expected sample=%0d under=0",
                         ds[k], s, u, exp_sample(ds[k]));
            else passed++;
        end
    endtask

    task automatic test_same_cycle();
        logic [DATA_W-1:0] s, e;
        logic u;
        int lat;
        do_flush();
        for (int i = 0; i < 10; i++) write_one(DATA_W'($urandom));
        e = exp_sample(0);
        sample_valid = 1'b1;
        sample_in    = 16'hBEEF;
        delay_valid  = 1'b1;
        delay_in     = '0;
        tick();
        sample_valid = 1'b0;
        delay_valid  = 1'b0;
        hist.push_back(16'hBEEF);
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        total++;
        if (out_sample !== e || out_underrun !== 1'b0 || lat != 2)
            $display("FAIL same_cycle_old: got sample=%h under=%b lat=%0d expected sample=%h under=0 lat=2",
                     out_sample, out_underrun, lat, e);
        else passed++;
        tick();
        total++;
        if (fill_level !== 10'(exp_fill())) $display("FAIL same_cycle_fill: got %0d expected %0d", fill_level, exp_fill());
        else passed++;
        do_request(0, 1'b1, s, u, lat);
        total++;
        if (s !== exp_sample(0) || u !== 1'b0)
            $display("FAIL same_cycle_new: got sample=%h under=%b expected sample=%h under=0", s, u, exp_sample(0));
        else passed++;
    endtask

    task automatic test_backpressure();
        logic [DATA_W-1:0] s, es;
        logic u, eu;
        int lat, d;
        for (int i = 0; i < 20; i++) write_one(DATA_W'($urandom));
        d  = $urandom_range(0, 40);
        es = exp_sample(d);
        eu = exp_under(d);
        out_ready = 1'b0;
        do_request(d, 1'b0, s, u, lat);
        total++;
        if (s !== es || u !== eu || lat != 2)
            $display("FAIL bp_first: got sample=%h under=%b lat=%0d expected sample=%h under=%b lat=2",
                     s, u, lat, es, eu);
        else passed++;
        for (int i = 0; i < 5; i++) begin
            sample_valid = (i % 2 == 0);
            sample_in    = DATA_W'($urandom);
            if (sample_valid) hist.push_back(sample_in);
            tick();
            sample_valid = 1'b0;
            total++;
            if (out_valid !== 1'b1 || out_sample !== es || out_underrun !== eu || delay_ready !== 1'b0)
                $display("FAIL bp_hold%0d: got valid=%b sample=%h under=%b ready=%b expected 1 %h %b 0",
                         i, out_valid, out_sample, out_underrun, delay_ready, es, eu);
            else passed++;
        end
        out_ready = 1'b1;
        tick();
        total++;
        if (out_valid !== 1'b0 || delay_ready !== 1'b1)
            $display("FAIL bp_release: got valid=%b ready=%b expected 0 1", out_valid, delay_ready);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int acc [$];
        int outs [$];
        logic [DATA_W-1:0] exps [$];
        logic [DATA_W-1:0] gots [$];
        int d;
        bit took;
        d = $urandom_range(0, 60);
        out_ready   = 1'b1;
        delay_valid = 1'b1;
        delay_in    = DELAY_W'(d);
        for (int k = 0; k < 9; k++) begin
            took = delay_ready;
            if (took) begin
                acc.push_back(cyc);
                exps.push_back(exp_sample(d));
            end
            tick();
            if (took) begin
                d = $urandom_range(0, 60);
                delay_in = DELAY_W'(d);
            end
            if (out_valid) begin
                outs.push_back(cyc);
                gots.push_back(out_sample);
            end
        end
        delay_valid = 1'b0;
        total++;
        if (acc.size() != 3 || outs.size() != 3)
            $display("FAIL b2b_count: got accepts=%0d outputs=%0d expected 3 3", acc.size(), outs.size());
        else passed++;
        if (acc.size() == 3) begin
            total++;
            if (acc[1] - acc[0] != 3 || acc[2] - acc[0] != 6)
                $display("FAIL b2b_spacing: got +%0d +%0d expected +3 +6", acc[1] - acc[0], acc[2] - acc[0]);
            else passed++;
        end
        for (int i = 0; i < 3; i++) begin
            if (i < acc.size() && i < outs.size()) begin
                total++;
                if (outs[i] != acc[i] + 2 || gots[i] !== exps[i])
                    $display("FAIL b2b_out%0d: got cycle=+%0d sample=%h expected cycle=+2 sample=%h",
                             i, outs[i] - acc[i], gots[i], exps[i]);
                else passed++;
            end
        end
        tick();
    endtask

    task automatic test_flush();
        logic [DATA_W-1:0] s;
        logic u;
        int lat;
        bit seen;
        for (int i = 0; i < 5; i++) write_one(DATA_W'($urandom));
        out_ready   = 1'b1;
        delay_valid = 1'b1;
        delay_in    = '0;
        tick();
        delay_valid = 1'b0;
        do_flush();
        total++;
        if (out_valid !== 1'b0 || fill_level !== '0)
            $display("FAIL flush_read: got valid=%b fill=%0d expected 0 0", out_valid, fill_level);
        else passed++;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) $display("FAIL flush_dropped: got out_valid=1 expected 0");
        else passed++;
        do_request(0, 1'b1, s, u, lat);
        total++;
        if (u !== exp_under(0) || s !== exp_sample(0))
            $display("FAIL flush_underrun: got sample=%h under=%b expected sample=%h under=%b",
                     s, u, exp_sample(0), exp_under(0));
        else passed++;
        for (int i = 0; i < 3; i++) write_one(DATA_W'($urandom));
        sample_valid = 1'b1;
        sample_in    = DATA_W'($urandom);
        do_flush();
        sample_valid = 1'b0;
        total++;
        if (fill_level !== '0) $display("FAIL flush_dominates: got fill=%0d expected 0", fill_level);
        else passed++;
    endtask

    task automatic test_reset_in_out();
        logic [DATA_W-1:0] s;
        logic u;
        int lat;
        bit seen;
        for (int i = 0; i < 4; i++) write_one(DATA_W'($urandom));
        out_ready = 1'b0;
        do_request(1, 1'b0, s, u, lat);
        total++;
        if (out_valid !== 1'b1) $display("FAIL rst_out_pre: got valid=%b expected 1", out_valid);
        else passed++;
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || delay_ready !== 1'b0 || fill_level !== '0 || out_sample !== '0)
            $display("FAIL rst_out_async: got valid=%b ready=%b fill=%0d sample=%h expected 0 0 0 0000",
                     out_valid, delay_ready, fill_level, out_sample);
        else passed++;
        tick();
        reset = 1'b0;
        hist.delete();
        out_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0 || delay_ready !== 1'b1)
            $display("FAIL rst_out_after: got seen_valid=%b ready=%b expected 0 1", seen, delay_ready);
        else passed++;
    endtask

    task automatic test_random();
        logic [DATA_W-1:0] s;
        logic u;
        int lat, d, n;
        do_flush();
        out_ready = 1'b1;
        for (int r = 0; r < 30; r++) begin
            n = (r == 15) ? 300 : $urandom_range(0, 20);
            for (int i = 0; i < n; i++) write_one(DATA_W'($urandom));
            d = (r % 3 == 0) ? $urandom_range(0, 15) : $urandom_range(0, 255);
            do_request(d, 1'b1, s, u, lat);
            total++;
            if (s !== exp_sample(d) || u !== exp_under(d) || lat != 2)
                $display("FAIL rand%0d_d%0d: got sample=%h under=%b lat=%0d expected sample=%h under=%b lat=2",
                         r, d, s, u, lat, exp_sample(d), exp_under(d));
            else passed++;
        end
        total++;
        if (fill_level !== 10'(exp_fill())) $display("FAIL rand_fill: got %0d expected %0d", fill_level, exp_fill());
        else passed++;
    endtask

    initial begin
        reset        = 1'b1;
        flush        = 1'b0;
        sample_valid = 1'b0;
        sample_in    = '0;
        delay_valid  = 1'b0;
        delay_in     = '0;
        out_ready    = 1'b1;
        test_reset();
        test_basic();
        test_wrap();
        test_same_cycle();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_in_out();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
